// File: rtl/if_stage_prefetch_if.sv
// Fetch-stage bundle: instruction memory port, decode handshake, redirect inputs and queue occupancy.
interface if_stage_prefetch_if #(
  parameter int WORD_LEN = 16,
  parameter int DEPTH    = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WORD_LEN-1:0] imem_addr;
  logic [WORD_LEN-1:0] imem_instr;
  logic                imem_valid;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_LEN-1:0] out_pc;
  logic [WORD_LEN-1:0] out_instr;
  logic                br_taken;
  logic [WORD_LEN-1:0] br_base;
  logic [WORD_LEN-1:0] br_offset;
  logic                jump_en;
  logic [CW-1:0]       count;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, count,
    input  imem_instr, imem_valid, out_ready, br_taken, br_base, br_offset, jump_en
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, count,
    output imem_instr, imem_valid, out_ready, br_taken, br_base, br_offset, jump_en
  );
endinterface

// File: rtl/if_stage_prefetch.sv
// Instruction fetch: PC generator feeding a DEPTH-entry {pc, instr} queue drained by decode;
// branch/jump redirects flush the queue and restart fetch at the target.
module if_stage_prefetch #(
  parameter int WORD_LEN     = 16,
  parameter int DEPTH        = 4,
  parameter int PC_STEP      = 4,
  parameter int OFFSET_SHIFT = 1,
  parameter int RESET_PC     = 0
) (
  input  logic clk,
  input  logic rst,
  if_stage_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_LEN-1:0]            pc, target, off_sh;
  logic [DEPTH-1:0][WORD_LEN-1:0] pc_mem, instr_mem;
  logic [AW-1:0]                  rptr, wptr;
  logic [CW-1:0]                  cnt;
  logic                           redirect, full, valid, pop, push;

  assign redirect = bus.jump_en | bus.br_taken;
  assign valid    = (cnt != '0);
  assign full     = (cnt == CW'(DEPTH));
  assign pop      = valid & bus.out_ready & ~redirect;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push     = bus.imem_valid & ~redirect & (~full | pop);

  assign off_sh = bus.br_offset << OFFSET_SHIFT;
  assign target = bus.jump_en ? off_sh : bus.br_base + off_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= WORD_LEN'(RESET_PC);
      cnt       <= '0;
      rptr      <= '0;
      wptr      <= '0;
      pc_mem    <= '0;
      instr_mem <= '0;
    end else if (redirect) begin
      pc   <= target;
      cnt  <= '0;
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (push) begin
        pc_mem[wptr]    <= pc;
        instr_mem[wptr] <= bus.imem_instr;
        pc              <= pc + WORD_LEN'(PC_STEP);
        wptr            <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign bus.imem_addr = pc;
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? pc_mem[rptr]    : '0;
  assign bus.out_instr = valid ? instr_mem[rptr] : '0;
  assign bus.count     = cnt;
endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: queue-level reference model compared every cycle, plus directed literal checks.
module tb_if_stage_prefetch;
  localparam int WL = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_prefetch_if #(.WORD_LEN(WL), .DEPTH(DEPTH)) bus ();

  if_stage_prefetch #(.WORD_LEN(WL), .DEPTH(DEPTH), .PC_STEP(4), .OFFSET_SHIFT(1), .RESET_PC(0))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: architectural PC plus an ordered list of fetched {pc, instr} pairs.
  logic [WL-1:0]   mpc;
  logic [2*WL-1:0] mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2*WL-1:0] head;
      head = (mq.size() != 0) ? mq[0] : '0;
      chk("m_addr",  32'(bus.imem_addr), 32'(mpc));
      chk("m_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("m_pc",    32'(bus.out_pc),    32'(head[2*WL-1:WL]));
      chk("m_instr", 32'(bus.out_instr), 32'(head[WL-1:0]));
      chk("m_count", 32'(bus.count),     32'(mq.size()));
    end
  end

  // One clock: randomise the fetched word, advance the model at the edge, return just after the next falling edge.
  task automatic step();
    bit p, s;
    bus.imem_instr = 16'($urandom);
    @(posedge clk);
    if (rst) begin
      mpc = '0;
      mq.delete();
    end else if (bus.jump_en || bus.br_taken) begin
      mpc = bus.jump_en ? 16'(bus.br_offset << 1) : 16'(bus.br_base + (bus.br_offset << 1));
      mq.delete();
    end else begin
      p = (mq.size() != 0) && bus.out_ready;
      s = bus.imem_valid && ((mq.size() < DEPTH) || p);
      if (p) void'(mq.pop_front());
      if (s) begin
        mq.push_back({mpc, bus.imem_instr});
        mpc = mpc + 16'd4;
      end
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_valid = 0; bus.out_ready = 0; bus.br_taken = 0; bus.jump_en = 0;
    bus.br_base = '0; bus.br_offset = '0; bus.imem_instr = '0;
    mpc = '0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_addr",  32'(bus.imem_addr), 0);
    chk("rst_pc",    32'(bus.out_pc), 0);

    // Streaming at one instruction per cycle.
    rst = 0; bus.imem_valid = 1; bus.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stream_addr",  32'(bus.imem_addr), 32'(4*(k+1)));
      chk("stream_pc",    32'(bus.out_pc), 32'(4*k));
      chk("stream_count", 32'(bus.count), 1);
    end

    // Backpressure fill, then drain without a bubble.
    rst = 1; step(); rst = 0; bus.out_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("bp_count", 32'(bus.count), 32'((k < 4) ? k : 4));
      chk("bp_pc",    32'(bus.out_pc), 0);
    end
    chk("bp_addr", 32'(bus.imem_addr), 16);
    bus.out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("drain_pc", 32'(bus.out_pc), 32'(4*(k+1)));
    end

    // Branch flush with the queue holding 8..20.
    rst = 1; step(); rst = 0; bus.out_ready = 0;
    repeat (4) step();
    bus.out_ready = 1;
    repeat (2) step();
    chk("brq_pc",    32'(bus.out_pc), 8);
    chk("brq_count", 32'(bus.count), 4);
    bus.br_taken = 1; bus.br_base = 16'd8; bus.br_offset = 16'd6;
    step();
    chk("br_count", 32'(bus.count), 0);
    chk("br_valid", 32'(bus.out_valid), 0);
    chk("br_addr",  32'(bus.imem_addr), 20);
    bus.br_taken = 0; bus.out_ready = 0;
    step();
    chk("br_pc", 32'(bus.out_pc), 20);

    // Jump wins over branch.
    bus.jump_en = 1; bus.br_taken = 1; bus.br_offset = 16'h0100; bus.br_base = 16'h0040;
    step();
    chk("jmp_addr", 32'(bus.imem_addr), 32'h0200);
    bus.br_taken = 0;

    // PC wrap and memory stall.
    bus.br_offset = 16'h7FFC;
    step();
    chk("wrap_a0", 32'(bus.imem_addr), 32'hFFF8);
    bus.jump_en = 0; bus.out_ready = 1;
    step();
    chk("wrap_a1", 32'(bus.imem_addr), 32'hFFFC);
    step();
    chk("wrap_a2", 32'(bus.imem_addr), 32'h0000);
    chk("wrap_pc", 32'(bus.out_pc), 32'hFFFC);
    bus.imem_valid = 0; bus.out_ready = 0;
    repeat (3) begin
      step();
      chk("stall_addr",  32'(bus.imem_addr), 0);
      chk("stall_count", 32'(bus.count), 1);
    end

    // Reset beats a simultaneous branch.
    bus.imem_valid = 1;
    repeat (2) step();
    chk("mid_count3", 32'(bus.count), 3);
    rst = 1; bus.br_taken = 1; bus.br_base = 16'h1234; bus.br_offset = 16'h0010;
    step();
    chk("mid_addr",  32'(bus.imem_addr), 0);
    chk("mid_count", 32'(bus.count), 0);
    chk("mid_valid", 32'(bus.out_valid), 0);
    chk("mid_pc",    32'(bus.out_pc), 0);
    rst = 0; bus.br_taken = 0;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(63) == 0);
      bus.imem_valid = ($urandom_range(3) != 0);
      bus.out_ready  = $urandom_range(1);
      bus.br_taken   = ($urandom_range(15) == 0);
      bus.jump_en    = ($urandom_range(31) == 0);
      bus.br_base    = 16'($urandom);
      bus.br_offset  = 16'($urandom);
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
Parametrised instruction-fetch stage that replaces the single-register PC fetch with a PC generator and a DEPTH-entry prefetch queue of {pc, instruction} pairs. It fetches sequentially from an external combinational instruction memory whenever there is room in the queue. It presents the queue head to decode through a valid/ready handshake, which replaces the freeze input. Branch (PC-relative) and jump (absolute) redirects flush the queue and restart fetch at the target.

Parameters:
WORD_LEN, 16, width of PC, offsets and instruction word
DEPTH, 4, prefetch queue entries; power of two, >= 2
PC_STEP, 4, PC increment per fetched instruction
OFFSET_SHIFT, 1, left shift applied to br_offset for both branch and jump targets
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  WORD_LEN  fetch address; equals the current PC register
imem_instr  in  WORD_LEN  instruction at imem_addr, valid in the same cycle
imem_valid  in  1  memory has a valid instruction this cycle; 0 means wait
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts the head this cycle; 0 is the equivalent of freeze
out_pc  out  WORD_LEN  PC of the head instruction; 0 when out_valid=0
out_instr  out  WORD_LEN  head instruction; 0 when out_valid=0
br_taken  in  1  branch redirect, target = br_base + (br_offset << OFFSET_SHIFT)
br_base  in  WORD_LEN  PC of the branch instruction, supplied by decode
br_offset  in  WORD_LEN  branch/jump offset
jump_en  in  1  jump redirect, target = br_offset << OFFSET_SHIFT
count  out  log2(DEPTH)+1  number of valid queue entries

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - PC <= RESET_PC; count, read pointer and write pointer <= 0; all storage cleared to 0.
  - out_valid=0; out_pc and out_instr are 0.
  - Reset asserted mid-operation discards all queue contents and any redirect in the same cycle. Reset has highest priority.
- Definitions:
  - redirect = jump_en | br_taken.
  - full = (count == DEPTH).
  - pop = out_valid & out_ready & ~redirect.
  - push = imem_valid & ~redirect & (~full | pop).
- Redirect:
  - jump_en has priority over br_taken when both are high.
  - The target is computed modulo 2^WORD_LEN.
  - Next edge: PC <= target; count and pointers <= 0; no push and no pop that cycle, so the head is not consumed even if out_ready=1.
  - The next cycle shows out_valid=0 and imem_addr=target.
  - Redirect latency: target instruction appears at out_valid two edges after the redirect cycle, provided imem_valid=1.
- Push:
  - Writes {PC, imem_instr} at the write pointer; PC <= PC + PC_STEP, wrapping modulo 2^WORD_LEN; write pointer increments modulo DEPTH.
  - If push=0 and there is no redirect, PC holds.
- Pop:
  - Read pointer increments modulo DEPTH.
  - out_pc and out_instr come combinationally from the head slot, masked to 0 when count == 0.
- Count:
  - count += push - pop. Push and pop in the same cycle leave it unchanged.
  - Full with pop: push is allowed in the same cycle.
  - Empty: pop is impossible, since out_valid=0.
- Fetch-to-output latency with an empty queue: 1 edge. The instruction fetched in cycle N is visible on out_* in cycle N+1.
- out_valid = (count != 0); it is registered state, not combinational from imem_valid.
- Handshake stability: while out_valid=1 and out_ready=0 with no redirect, out_pc and out_instr are held stable.
- Steady state with out_ready=1 and imem_valid=1: throughput of one instruction per cycle.

Test Plan:
- Reset then stream: rst for 2 cycles, imem_valid=1, out_ready=1, DEPTH=4. Required: imem_addr 0,4,8,… each cycle; out_pc 0,4,8 starting one cycle after the first fetch; count stays at 1.
- Backpressure fill: out_ready=0 from reset. Required: count rises 1,2,3,4 and stops; imem_addr holds at 16; out_pc=0 held stable. Release out_ready: out_pc 0,4,8,12,16 consecutively, with no bubble at the full-and-pop transition.
- Branch flush: queue holds PCs 8..20; br_taken=1, br_base=8, br_offset=6. Required: next cycle count=0, out_valid=0, imem_addr=20 (8+12). Following cycle out_pc=20. The head was not consumed during the redirect cycle.
- Jump priority: jump_en=1 and br_taken=1 together, br_offset=0x0100, br_base=0x40. Required: PC=0x0200 (jump target), not 0x240.
- Wrap and imem stall: RESET_PC=0xFFF8, PC_STEP=4. Required: fetch addresses 0xFFF8, 0xFFFC, 0x0000. Hold imem_valid=0 for 3 cycles: PC and count are unchanged and no entries are written.
- Reset mid-operation: rst=1 with count=3 and br_taken=1 in the same cycle. Required: next cycle PC=RESET_PC, count=0, out_valid=0, out_pc=0.
